// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state encoding,
// default operand width and the Booth recoding pair codes {Q[0],QM1}.
package booth_pkg;

  localparam int BOOTH_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into ACC, then an
// arithmetic right shift of the combined {ACC,Q,QM1} register.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_W_DEFAULT
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             qm1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      default:   sum = acc;
    endcase
    // ACC carries one guard bit, so its MSB is the true sign to replicate
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    qm1_next = q[0];
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: start/done handshake, one Booth step
// per clock, registered signed product held until the next accepted start.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_next;

  logic [WIDTH:0]   m, acc, acc_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic             qm1, qm1_nx;
  logic [CW-1:0]    count;
  logic             last_step;

  assign last_step = (count == CW'(1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .qm1      (qm1),
    .m        (m),
    .acc_next (acc_nx),
    .q_next   (q_nx),
    .qm1_next (qm1_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      count <= '0;
      P     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= {A[WIDTH-1], A};
            acc   <= '0;
            q     <= B;
            qm1   <= 1'b0;
            count <= CW'(WIDTH);
          end
        end
        ST_RUN: begin
          acc   <= acc_nx;
          q     <= q_nx;
          qm1   <= qm1_nx;
          count <= count - CW'(1);
          // Guard bit of ACC is dropped: the true product always fits in 2*WIDTH
          if (last_step) P <= {acc_nx[WIDTH-1:0], q_nx};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl at WIDTH=4: handshake timing,
// signed products, continuous start, async reset mid-run and a full sweep.
module tb_booth_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A, B;
  logic       ready, busy, done;
  logic [7:0] P;

  int n_checks = 0;
  int n_fail   = 0;

  booth_seq_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  // Issue one start from IDLE, measure edges to done, check product and hold
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string tag, input bit full);
    int lat;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    if (full) check({tag, "_ready_pre"}, ready, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a; B = ~b;
    if (full) check({tag, "_busy_run"}, {ready, busy}, 2'b01);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_P"}, P, exp);
    if (full) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {done, ready, busy}, 3'b010);
      check({tag, "_P_hold"}, P, exp);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] a_tab [18];
  logic [3:0] b_tab [18];
  logic [7:0] exp_p;

  initial begin
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    rst_n = 1'b0;
    #12;
    check("reset_outputs", {ready, busy, done}, 3'b100);
    check("reset_P", P, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed products");
    run_op(4'b1001, 4'b1001, 8'h31, "m7xm7", 1);
    run_op(4'b0001, 4'b1101, 8'hFD, "1xm3", 1);
    run_op(4'b0000, 4'b1101, 8'h00, "0xm3", 1);
    run_op(4'b1000, 4'b0000, 8'h00, "m8x0", 1);
    run_op(4'b1000, 4'b1000, 8'h40, "m8xm8", 1);
    run_op(4'b1001, 4'b0111, 8'hCF, "m7x7", 1);
    run_op(4'b0010, 4'b0111, 8'h0E, "2x7", 1);

    $display("[TB] start held high, operands changing every cycle");
    for (int i = 0; i < 18; i++) begin
      a_tab[i] = 4'($urandom_range(0, 15));
      b_tab[i] = 4'($urandom_range(0, 15));
    end
    exp_p = 8'h0E;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      A = a_tab[i];
      B = b_tab[i];
      start = 1'b1;
      @(posedge clk);
      #1;
      if (i % 6 == 4) exp_p = ref_mul(a_tab[i-4], b_tab[i-4]);
      check($sformatf("cont_ready_%0d", i), ready, (i % 6 == 5) ? 1 : 0);
      check($sformatf("cont_done_%0d", i), done, (i % 6 == 4) ? 1 : 0);
      check($sformatf("cont_P_%0d", i), P, exp_p);
    end
    start = 1'b0;

    $display("[TB] async reset mid-run");
    @(negedge clk);
    A = 4'b0111; B = 4'b0111; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {ready, busy, done}, 3'b100);
    check("rst_mid_P", P, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_no_done", {ready, busy, done}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'b1111, 4'b1001, 8'h07, "post_rst", 1);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), ref_mul(4'(a), 4'(b)), $sformatf("sweep_%0d_%0d", a, b), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
